// File: rtl/hazard_ctrl_if.sv
// Hazard-unit signal bundle: pipeline stage register addresses and controls in, forwarding,
// stall/flush and status out. The master modport drives stage info; the slave is the hazard unit.
interface hazard_ctrl_if #(
  parameter int unsigned CNTW = 16
);
  logic [4:0]      rs1d;
  logic [4:0]      rs2d;
  logic [4:0]      rs1e;
  logic [4:0]      rs2e;
  logic [4:0]      rde;
  logic [1:0]      resrce;
  logic            pcsrce;
  logic [4:0]      rdm;
  logic            regwm;
  logic [4:0]      rdw;
  logic            regww;
  logic            dmem_req;
  logic            dmem_rdy;
  logic [1:0]      fwdae;
  logic [1:0]      fwdbe;
  logic            stallf;
  logic            stalld;
  logic            stalle;
  logic            stallm;
  logic            flushd;
  logic            flushe;
  logic            flushw;
  logic            err;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output rs1d, rs2d, rs1e, rs2e, rde, resrce, pcsrce, rdm, regwm, rdw, regww,
    output dmem_req, dmem_rdy,
    input  fwdae, fwdbe, stallf, stalld, stalle, stallm, flushd, flushe, flushw,
    input  err, stall_cnt
  );

  modport slave (
    input  rs1d, rs2d, rs1e, rs2e, rde, resrce, pcsrce, rdm, regwm, rdw, regww,
    input  dmem_req, dmem_rdy,
    output fwdae, fwdbe, stallf, stalld, stalle, stallm, flushd, flushe, flushw,
    output err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit for the 5-stage core: EX operand forwarding, load-use bubble, branch
// flush, full freeze while a data-memory access waits, stall counter and sticky timeout error.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {StRun, StMwait, StErr} state_e;

  state_e          state_q;
  logic [7:0]      wait_q;
  logic            err_q;
  logic [CNTW-1:0] cnt_q;

  logic lwstall;
  logic memstall;
  logic stallf;

  // MEM-stage result takes priority over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic regwm, input logic [4:0] rdw,
                                         input logic regww);
    if (regwm && (rdm != 5'd0) && (rdm == rs)) begin
      return 2'b10;
    end else if (regww && (rdw != 5'd0) && (rdw == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    hz.fwdae = fwd_sel(hz.rs1e, hz.rdm, hz.regwm, hz.rdw, hz.regww);
    hz.fwdbe = fwd_sel(hz.rs2e, hz.rdm, hz.regwm, hz.rdw, hz.regww);
  end

  always_comb begin
    lwstall  = (hz.resrce == 2'b01) && (hz.rde != 5'd0) &&
               ((hz.rde == hz.rs1d) || (hz.rde == hz.rs2d));
    memstall = ((state_q == StRun) && hz.dmem_req && !hz.dmem_rdy) ||
               ((state_q == StMwait) && !hz.dmem_rdy) ||
               (state_q == StErr);
  end

  // A memory freeze overrides load-use and branch handling; they re-evaluate afterwards.
  always_comb begin
    stallf    = 1'b0;
    hz.stalld = 1'b0;
    hz.stalle = 1'b0;
    hz.stallm = 1'b0;
    hz.flushd = 1'b0;
    hz.flushe = 1'b0;
    hz.flushw = 1'b0;
    if (memstall) begin
      stallf    = 1'b1;
      hz.stalld = 1'b1;
      hz.stalle = 1'b1;
      hz.stallm = 1'b1;
      hz.flushw = 1'b1;
    end else begin
      stallf    = lwstall && !hz.pcsrce;
      hz.stalld = lwstall && !hz.pcsrce;
      hz.flushd = hz.pcsrce;
      hz.flushe = hz.pcsrce || lwstall;
    end
  end

  assign hz.stallf    = stallf;
  assign hz.err       = err_q;
  assign hz.stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (stallf && (cnt_q != {CNTW{1'b1}})) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
      unique case (state_q)
        StRun: begin
          if (hz.dmem_req && !hz.dmem_rdy) begin
            state_q <= StMwait;
            wait_q  <= 8'd1;
          end
        end
        StMwait: begin
          if (hz.dmem_rdy) begin
            state_q <= StRun;
            wait_q  <= 8'd0;
          end else if (wait_q == 8'(TIMEOUT - 1)) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StErr: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued as stimulus is applied and
// compared against the DUT on the following falling clock edge.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNTW    = 16;

  // Control bit order: stallf stalld stalle stallm flushd flushe flushw err
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_0100;
  localparam logic [7:0] BR   = 8'b0000_1100;
  localparam logic [7:0] MEM  = 8'b1111_0010;
  localparam logic [7:0] ERRS = 8'b1111_0011;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  logic   clk;
  logic   rst_n;
  exp_t   sb[$];
  string  tags[$];
  int     checks;
  int     errors;

  hazard_ctrl_if #(.CNTW(CNTW)) hz();

  hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNTW    (CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [7:0] ctl, input logic [15:0] cnt);
    exp_t e;
    e.fa  = fa;
    e.fb  = fb;
    e.ctl = ctl;
    e.cnt = cnt;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic check_now();
    exp_t  e;
    exp_t  obs;
    string tag;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      tag = tags.pop_front();
      obs.fa  = hz.fwdae;
      obs.fb  = hz.fwdbe;
      obs.ctl = {hz.stallf, hz.stalld, hz.stalle, hz.stallm,
                 hz.flushd, hz.flushe, hz.flushw, hz.err};
      obs.cnt = hz.stall_cnt;
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s got fa=%b fb=%b ctl=%b cnt=%h expected fa=%b fb=%b ctl=%b cnt=%h",
               tag, obs.fa, obs.fb, obs.ctl, obs.cnt, e.fa, e.fb, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hz.rs1d = 5'd0; hz.rs2d = 5'd0; hz.rs1e = 5'd0; hz.rs2e = 5'd0;
    hz.rde = 5'd0; hz.resrce = 2'b00; hz.pcsrce = 1'b0;
    hz.rdm = 5'd0; hz.regwm = 1'b0; hz.rdw = 5'd0; hz.regww = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_rdy = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr_in();
    #1;
    push("reset", 2'b00, 2'b00, NONE, 16'd0);
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Forwarding
    hz.regwm = 1'b1; hz.rdm = 5'd5; hz.regww = 1'b1; hz.rdw = 5'd5;
    hz.rs1e = 5'd5; hz.rs2e = 5'd0;
    push("fwd_mem", 2'b10, 2'b00, NONE, 16'd0); cyc();
    hz.regwm = 1'b0;
    push("fwd_wb", 2'b01, 2'b00, NONE, 16'd0); cyc();
    hz.rdm = 5'd0; hz.rdw = 5'd0; hz.rs1e = 5'd0;
    push("fwd_x0", 2'b00, 2'b00, NONE, 16'd0); cyc();
    hz.regwm = 1'b1; hz.rdm = 5'd3; hz.regww = 1'b1; hz.rdw = 5'd4;
    hz.rs1e = 5'd4; hz.rs2e = 5'd3;
    push("fwd_split", 2'b01, 2'b10, NONE, 16'd0); cyc();
    hz.rdw = 5'd3;
    push("fwd_prio", 2'b00, 2'b10, NONE, 16'd0); cyc();
    clr_in();

    // Load-use and branch
    hz.resrce = 2'b01; hz.rde = 5'd7; hz.rs2d = 5'd7;
    push("lu_rs2", 2'b00, 2'b00, LU, 16'd0); cyc();
    clr_in();
    push("lu_after", 2'b00, 2'b00, NONE, 16'd1); cyc();
    hz.resrce = 2'b01; hz.rde = 5'd7; hz.rs2d = 5'd7; hz.pcsrce = 1'b1;
    push("lu_branch", 2'b00, 2'b00, BR, 16'd1); cyc();
    hz.pcsrce = 1'b0; hz.rde = 5'd0; hz.rs2d = 5'd0; hz.rs1d = 5'd0;
    push("lu_x0", 2'b00, 2'b00, NONE, 16'd1); cyc();
    hz.rde = 5'd9; hz.rs1d = 5'd9;
    push("lu_rs1", 2'b00, 2'b00, LU, 16'd1); cyc();
    hz.resrce = 2'b10;
    push("lu_notload", 2'b00, 2'b00, NONE, 16'd2); cyc();
    clr_in();

    // Memory wait, three cycles without ready
    reset_pulse();
    hz.dmem_req = 1'b1;
    push("mw_1", 2'b00, 2'b00, MEM, 16'd0); cyc();
    hz.resrce = 2'b01; hz.rde = 5'd7; hz.rs2d = 5'd7; hz.pcsrce = 1'b1;
    push("mw_2_supp", 2'b00, 2'b00, MEM, 16'd1); cyc();
    hz.resrce = 2'b00; hz.rde = 5'd0; hz.rs2d = 5'd0; hz.pcsrce = 1'b0;
    push("mw_3", 2'b00, 2'b00, MEM, 16'd2); cyc();
    hz.dmem_rdy = 1'b1;
    push("mw_rdy", 2'b00, 2'b00, NONE, 16'd3); cyc();
    hz.dmem_req = 1'b0; hz.dmem_rdy = 1'b0;
    push("mw_run", 2'b00, 2'b00, NONE, 16'd3); cyc();
    hz.dmem_rdy = 1'b1;
    push("rdy_noreq", 2'b00, 2'b00, NONE, 16'd3); cyc();
    hz.dmem_req = 1'b1;
    push("req_rdy", 2'b00, 2'b00, NONE, 16'd3); cyc();
    clr_in();

    // Timeout into the sticky error state
    reset_pulse();
    hz.dmem_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      push("tmo_wait", 2'b00, 2'b00, MEM, 16'(i - 1)); cyc();
    end
    push("tmo_err", 2'b00, 2'b00, ERRS, 16'd16); cyc();
    hz.dmem_req = 1'b0; hz.dmem_rdy = 1'b1;
    push("err_hold", 2'b00, 2'b00, ERRS, 16'd17); cyc();

    // Counter saturation while frozen in the error state
    repeat (65516) @(posedge clk);
    #1;
    push("sat_near", 2'b00, 2'b00, ERRS, 16'hFFFE); cyc();
    push("sat_max", 2'b00, 2'b00, ERRS, 16'hFFFF); cyc();
    push("sat_hold", 2'b00, 2'b00, ERRS, 16'hFFFF); cyc();

    // Reset leaves the error state
    hz.dmem_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    push("rst_err", 2'b00, 2'b00, NONE, 16'd0);
    check_now();
    #1;
    rst_n = 1'b1;
    push("post_rst", 2'b00, 2'b00, NONE, 16'd0); cyc();

    // Asynchronous reset in the middle of a memory wait
    hz.dmem_req = 1'b1;
    push("am_run", 2'b00, 2'b00, MEM, 16'd0); cyc();
    push("am_wait", 2'b00, 2'b00, MEM, 16'd1); cyc();
    #2;
    hz.dmem_req = 1'b0;
    #1;
    push("am_pre", 2'b00, 2'b00, MEM, 16'd2);
    check_now();
    rst_n = 1'b0;
    #1;
    push("am_rst", 2'b00, 2'b00, NONE, 16'd0);
    check_now();
    #1;
    rst_n = 1'b1;
    push("am_after", 2'b00, 2'b00, NONE, 16'd0); cyc();
    push("am_idle", 2'b00, 2'b00, NONE, 16'd0); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
